// File: rtl/psk_bit_scheduler.sv
// Serialises N useful bits per word (or one bit in BPSK mode) onto a one-bit stream, each bit held div+1 clocks.
// Optional UNDERRUN_CNT_EN adds a saturating count of returns to IDLE with no follow-on word.
module psk_bit_scheduler #(
  parameter int N                = 2,
  parameter int M                = 8,
  parameter int BYPASS_SELECTION = 1,
  parameter int DIV_W            = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                is_bpsk,
  input  logic [DIV_W-1:0]                    div,
  input  logic [M-1:0]                        I,
  input  logic                                I_vld,
  output logic                                I_rdy,
  output logic                                O,
  output logic                                O_vld,
  output logic                                sym_stb,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] bit_idx,
  output logic                                mode_bpsk
`ifdef UNDERRUN_CNT_EN
  ,output logic [15:0]                        underrun_cnt
`endif
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a word transfers on a rising edge where I_vld and I_rdy are both 1;
  // the source holds I and I_vld stable until that edge.
  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     word_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [IW-1:0]    idx_q;
  logic             stb_q;
  logic             mode_q;
  logic             last_bit;
  logic             accept;
  logic             unused_bits;

  assign unused_bits = ^I;
  assign sym_stb     = stb_q;
  assign bit_idx     = idx_q;
  assign mode_bpsk   = mode_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    I_rdy     = 1'b0;
    O_vld     = 1'b0;
    O         = 1'b0;
    last_bit  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: I_rdy = !rst;
      SHIFT: begin
        O_vld    = 1'b1;
        O        = word_q[idx_q];
        last_bit = (div_cnt == '0) && (mode_q || (idx_q == IW'(N - 1)));
        I_rdy    = last_bit && !rst;
      end
      default: state_nxt = IDLE;
    endcase
    accept = I_vld && I_rdy;
    if (accept)        state_nxt = SHIFT;
    else if (last_bit) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      div_q   <= '0;
      div_cnt <= '0;
      idx_q   <= '0;
      stb_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (accept) begin
        word_q  <= I[N-1:0];
        mode_q  <= is_bpsk;
        div_q   <= div;
        div_cnt <= div;
        idx_q   <= is_bpsk ? IW'(BYPASS_SELECTION) : '0;
        stb_q   <= 1'b1;
      end else if (state == SHIFT) begin
        if (div_cnt == '0) begin
          // Bit period expired: either finish the word or move to the next bit.
          if (last_bit) begin
            idx_q <= '0;
          end else begin
            idx_q   <= idx_q + IW'(1);
            div_cnt <= div_q;
          end
        end else begin
          div_cnt <= div_cnt - DIV_W'(1);
        end
      end
    end
  end

`ifdef UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                      underrun_cnt <= '0;
    else if (last_bit && !accept && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_psk_bit_scheduler.sv
// Directed bench for psk_bit_scheduler: inputs change and outputs are sampled on the falling edge.
// Underrun checks are compiled in only when UNDERRUN_CNT_EN is defined.
module tb_psk_bit_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_bpsk;
  logic [15:0] div;
  logic [7:0]  I;
  logic        I_vld;
  logic        I_rdy;
  logic        O;
  logic        O_vld;
  logic        sym_stb;
  logic [0:0]  bit_idx;
  logic        mode_bpsk;
`ifdef UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];
  logic [0:0] stb_q[$];

  psk_bit_scheduler #(.N(2), .M(8), .BYPASS_SELECTION(1), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .is_bpsk(is_bpsk), .div(div), .I(I), .I_vld(I_vld),
    .I_rdy(I_rdy), .O(O), .O_vld(O_vld), .sym_stb(sym_stb), .bit_idx(bit_idx),
    .mode_bpsk(mode_bpsk)
`ifdef UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; is_bpsk = 1'b0; div = '0; I = '0; I_vld = 1'b0;

    // Reset then idle
    repeat (2) begin
      tick();
      check("rst_rdy", I_rdy, 0);
      check("rst_o", O, 0);
      check("rst_vld", O_vld, 0);
      check("rst_stb", sym_stb, 0);
      check("rst_idx", bit_idx, 0);
      check("rst_mode", mode_bpsk, 0);
    end
    rst = 1'b0;
    #1 check("rdy_after_rst", I_rdy, 1);
    tick();
    check("idle_vld", O_vld, 0);
    check("idle_rdy", I_rdy, 1);

    // QPSK, div=0, word A2 -> bits 0,1
    I = 8'hA2; I_vld = 1'b1; is_bpsk = 1'b0; div = 16'd0;
    tick();
    check("q_c1_vld", O_vld, 1); check("q_c1_o", O, 0);
    check("q_c1_idx", bit_idx, 0); check("q_c1_stb", sym_stb, 1);
    I_vld = 1'b0;
    tick();
    check("q_c2_vld", O_vld, 1); check("q_c2_o", O, 1);
    check("q_c2_idx", bit_idx, 1); check("q_c2_stb", sym_stb, 0);
    check("q_c2_rdy", I_rdy, 1);
    tick();
    check("q_end_vld", O_vld, 0); check("q_end_o", O, 0);

    // BPSK, div=3, word 02 -> bit 1 held 4 clocks
    I = 8'h02; I_vld = 1'b1; is_bpsk = 1'b1; div = 16'd3;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) I_vld = 1'b0;
      check("b_vld", O_vld, 1); check("b_o", O, 1);
      check("b_idx", bit_idx, 1); check("b_mode", mode_bpsk, 1);
      check("b_stb", sym_stb, (c == 1) ? 1 : 0);
      check("b_rdy", I_rdy, (c == 4) ? 1 : 0);
    end
    tick();
    check("b_end_vld", O_vld, 0);

    // Back-to-back QPSK, div=1, words 01 then 02
    exp_q = '{1, 1, 0, 0, 0, 0, 1, 1};
    stb_q = '{1, 0, 0, 0, 1, 0, 0, 0};
    I = 8'h01; I_vld = 1'b1; is_bpsk = 1'b0; div = 16'd1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check("bb_vld", O_vld, 1);
      check("bb_o", O, exp_q.pop_front());
      check("bb_stb", sym_stb, stb_q.pop_front());
      if (c == 4) check("bb_rdy_last", I_rdy, 1);
      if (c == 2) check("bb_rdy_mid", I_rdy, 0);
      if (c == 1) I = 8'h02;
      if (c == 5) I_vld = 1'b0;
    end
    tick();
    check("bb_end_vld", O_vld, 0);

    // Mode/div change mid-word: QPSK div=2 word 01, then BPSK div=0 word 02
    I = 8'h01; I_vld = 1'b1; is_bpsk = 1'b0; div = 16'd2;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin I_vld = 1'b0; is_bpsk = 1'b1; div = 16'd0; end
      check("mc_vld", O_vld, 1);
      check("mc_o", O, (c <= 3) ? 1 : 0);
      check("mc_idx", bit_idx, (c <= 3) ? 0 : 1);
      check("mc_mode", mode_bpsk, 0);
      if (c == 6) begin I = 8'h02; I_vld = 1'b1; end
    end
    tick();
    I_vld = 1'b0;
    check("mc_b_vld", O_vld, 1); check("mc_b_o", O, 1);
    check("mc_b_idx", bit_idx, 1); check("mc_b_stb", sym_stb, 1);
    check("mc_b_mode", mode_bpsk, 1);
    tick();
    check("mc_end_vld", O_vld, 0);

    // Reset during the 2nd bit of a QPSK div=1 word
    I = 8'h03; I_vld = 1'b1; is_bpsk = 1'b0; div = 16'd1;
    tick(); I_vld = 1'b0;
    tick();
    tick();
    check("rm_idx_pre", bit_idx, 1);
    rst = 1'b1;
    tick();
    check("rm_vld", O_vld, 0); check("rm_rdy", I_rdy, 0); check("rm_o", O, 0);
`ifdef UNDERRUN_CNT_EN
    check("rm_urun", underrun_cnt, 0);
`endif
    rst = 1'b0;
    tick();
    check("rm_vld2", O_vld, 0); check("rm_rdy2", I_rdy, 1); check("rm_idx", bit_idx, 0);

    // Three starved QPSK words, div=0
    for (int w = 0; w < 3; w++) begin
      I = 8'h03; I_vld = 1'b1; is_bpsk = 1'b0; div = 16'd0;
      tick(); I_vld = 1'b0;
      check("st_o0", O, 1);
      tick();
      check("st_o1", O, 1);
      tick();
      check("st_end_vld", O_vld, 0);
    end
`ifdef UNDERRUN_CNT_EN
    check("urun_3", underrun_cnt, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("urun_clr", underrun_cnt, 0);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psk_bit_scheduler.md
Name: psk_bit_scheduler

Overview:
Single-clock symbol scheduler ahead of the PSK mapper. It accepts M-bit symbol words over a valid/ready handshake and serialises the useful bits onto a one-bit stream, holding each bit for a programmable number of clocks. It latches the BPSK/QPSK mode per word, so a mode change takes effect only on a symbol boundary. It replaces the two-clock flattening path with a single-clock scheduler that applies back-pressure to the source.

Parameters:
N, 2, useful bits per symbol in multi-bit mode (N >= 2); bit index width is $clog2(N).
M, 8, input word width; bits above N-1 are ignored.
BYPASS_SELECTION, 1, bit of the word emitted in BPSK mode (0 <= BYPASS_SELECTION < N).
DIV_W, 16, width of the bit-period divider.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
is_bpsk  in  1  requested mode: 1 = BPSK (one bit per word), 0 = N bits per word; sampled on word acceptance.
div  in  DIV_W  clocks per bit minus 1; sampled on word acceptance.
I  in  M  input symbol word.
I_vld  in  1  input word valid.
I_rdy  out  1  scheduler can take a word this cycle.
O  out  1  serial bit; forced to 0 when O_vld = 0.
O_vld  out  1  O carries a scheduled bit.
sym_stb  out  1  one-cycle pulse on the first output cycle of each word.
bit_idx  out  $clog2(N)  index of the bit currently on O.
mode_bpsk  out  1  latched mode of the word in flight.

Behaviour:
- Reset: state IDLE; I_rdy=0 in the reset cycle and 1 afterwards; O=0, O_vld=0, sym_stb=0, bit_idx=0, mode_bpsk=0; word, divider and counters cleared. Reset mid-word discards the word with no partial output afterwards.
- A word is accepted on a clock where I_vld=1 and I_rdy=1. On acceptance the block latches I[N-1:0], is_bpsk into mode_bpsk, and div into div_q.
- States:
  - IDLE: I_rdy=1, O_vld=0. On acceptance, go to SHIFT.
  - SHIFT: O_vld=1.
- Latency: the first bit appears on O the cycle after acceptance, with sym_stb=1 in that cycle.
- SHIFT sequencing:
  - div_cnt loads div_q and decrements each clock.
  - At div_cnt=0 the block advances to the next bit and reloads div_cnt.
  - Each bit is held exactly div_q+1 clocks; div=0 gives one bit per clock.
- Bit order:
  - Multi-bit mode: O = word[bit_idx], bit_idx running 0..N-1, LSB first.
  - BPSK: exactly one bit, O = word[BYPASS_SELECTION], with bit_idx = BYPASS_SELECTION.
- Last-bit cycle (final bit with div_cnt=0): I_rdy=1.
  - If I_vld=1, the next word is accepted and its first bit follows with no gap: O_vld stays 1 and sym_stb pulses.
  - Otherwise the block returns to IDLE and O_vld drops the next cycle.
- Outside IDLE and the last-bit cycle, I_rdy=0. The source must hold I and I_vld stable until acceptance.
- Changes to is_bpsk or div while a word is in flight have no effect until the next acceptance.
- The divider counter is DIV_W wide with no wrap hazard; div = all-ones gives 2^DIV_W clocks per bit.

Optional Feature:
UNDERRUN_CNT_EN
- Defined: adds output underrun_cnt [15:0]. It increments, saturating at 16'hFFFF, on every SHIFT-to-IDLE transition (a last-bit cycle with I_vld=0). It is cleared by rst.
- Not defined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> O=0, O_vld=0, sym_stb=0; I_rdy=0 during reset and 1 from the first cycle after rst falls.
- QPSK with div=0, one word I=8'hA2 -> O=0 then 1 on consecutive cycles with bit_idx 0,1; sym_stb pulses in the first of these cycles; O_vld high for exactly 2 cycles.
- BPSK with div=3, I=8'h02 and BYPASS_SELECTION=1 -> O=1 held for 4 cycles with bit_idx=1; one sym_stb; I_rdy high only in the 4th cycle.
- Back-to-back QPSK with div=1, words 8'h01 and 8'h02 with I_vld held high -> O sequence 1,1,0,0,0,0,1,1; O_vld continuous for 8 cycles; sym_stb in cycles 1 and 5.
- Mode/div change mid-word: accept a QPSK word with div=2, then toggle is_bpsk=1 and div=0 during SHIFT -> the current word still emits 2 bits of 3 clocks each; the next accepted word is BPSK, 1 clock.
- Reset in the 2nd bit of a word -> O_vld=0 the next cycle; with UNDERRUN_CNT_EN, three starved words give underrun_cnt=3, and rst clears it to 0.
